// File: rtl/axi_lite_mem_pkg.sv
// axi_lite_mem_pkg: response codes and FSM encodings for the AXI4-Lite memory slave
package axi_lite_mem_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;
  typedef enum logic {W_IDLE, W_RESP} wstate_t;
endpackage

// File: rtl/axi_lite_mem_array.sv
// axi_lite_mem_array: word array with a registered read port and a byte-enabled write port
module axi_lite_mem_array #(
  parameter int DEPTH = 1024,
  parameter int IW    = 10,
  parameter int DW    = 32
) (
  input  logic              CLK,
  input  logic              i_rd_en,
  input  logic [IW-1:0]     i_rd_idx,
  output logic [DW-1:0]     o_rd_data,
  input  logic              i_wr_en,
  input  logic [IW-1:0]     i_wr_idx,
  input  logic [DW-1:0]     i_wr_data,
  input  logic [DW/8-1:0]   i_wr_strb
);
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_q;
  // Nonblocking read and write on the same edge gives read-before-write.
  always_ff @(posedge CLK) begin
    if (i_rd_en) r_q <= r_mem[i_rd_idx];
    if (i_wr_en)
      for (int b = 0; b < DW/8; b++)
        if (i_wr_strb[b]) r_mem[i_wr_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
  end
  assign o_rd_data = r_q;
endmodule

// File: rtl/axi_lite_mem_slave.sv
// axi_lite_mem_slave: AXI4-Lite responder over a word-addressed memory window,
// one outstanding read (with wait states) and one outstanding write.
module axi_lite_mem_slave
  import axi_lite_mem_pkg::*;
#(
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  DATA_WIDTH = 32,
  parameter int                  STRB_WIDTH = 4,
  parameter int                  PROT_WIDTH = 3,
  parameter int                  RESP_WIDTH = 2,
  parameter int                  MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int                  READ_WAIT  = 0
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [PROT_WIDTH-1:0] s_axi_arprot,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [RESP_WIDTH-1:0] s_axi_rresp,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [PROT_WIDTH-1:0] s_axi_awprot,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  output logic [RESP_WIDTH-1:0] s_axi_bresp
);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(4 * MEM_DEPTH);

  function automatic logic [1:0] dec(input logic [ADDR_WIDTH-1:0] off, input logic [1:0] lo);
    return ({1'b0, off} >= LIMIT) ? RESP_DECERR : (lo != 2'b00) ? RESP_SLVERR : RESP_OKAY;
  endfunction

  rstate_t r_rstate, w_rnext;
  wstate_t r_wstate, w_wnext;
  logic r_up, r_aw_held, r_w_held;
  logic [3:0] r_cnt;
  logic [1:0] r_rresp, r_bresp, w_wresp;
  logic [ADDR_WIDTH-1:0] r_araddr, r_awaddr, w_raddr, w_waddr, w_roff, w_woff;
  logic [DATA_WIDTH-1:0] r_wdata, w_wr_data, w_rd_data;
  logic [STRB_WIDTH-1:0] r_wstrb, w_wr_strb;
  logic w_ar_hs, w_aw_hs, w_w_hs, w_commit, w_rd_en, w_wr_en, w_unused;

  assign w_unused = ^{s_axi_arprot, s_axi_awprot};

  // r_up keeps every ready low until the first edge after reset release.
  assign s_axi_arready = r_up && r_rstate == R_IDLE;
  assign s_axi_awready = r_up && r_wstate == W_IDLE && !r_aw_held;
  assign s_axi_wready  = r_up && r_wstate == W_IDLE && !r_w_held;
  assign s_axi_rvalid  = r_rstate == R_RESP;
  assign s_axi_bvalid  = r_wstate == W_RESP;
  assign s_axi_rresp   = RESP_WIDTH'(r_rresp);
  assign s_axi_bresp   = RESP_WIDTH'(r_bresp);
  assign s_axi_rdata   = (s_axi_rvalid && r_rresp == RESP_OKAY) ? w_rd_data : '0;

  assign w_ar_hs = s_axi_arvalid && s_axi_arready;
  assign w_aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_w_hs  = s_axi_wvalid && s_axi_wready;

  assign w_raddr = r_rstate == R_IDLE ? s_axi_araddr : r_araddr;
  assign w_roff  = w_raddr - BASE_ADDR;
  assign w_rd_en = w_rnext == R_RESP && r_rstate != R_RESP;

  assign w_commit  = r_wstate == W_IDLE && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
  assign w_waddr   = r_aw_held ? r_awaddr : s_axi_awaddr;
  assign w_wr_data = r_w_held ? r_wdata : s_axi_wdata;
  assign w_wr_strb = r_w_held ? r_wstrb : s_axi_wstrb;
  assign w_woff    = w_waddr - BASE_ADDR;
  assign w_wresp   = dec(w_woff, w_waddr[1:0]);
  assign w_wr_en   = w_commit && w_wresp == RESP_OKAY;

  always_comb begin
    w_rnext = r_rstate == R_IDLE ? (w_ar_hs ? (READ_WAIT == 0 ? R_RESP : R_WAIT) : R_IDLE)
            : r_rstate == R_WAIT ? (r_cnt == 4'd1 ? R_RESP : R_WAIT)
            : (s_axi_rready ? R_IDLE : R_RESP);
    w_wnext = r_wstate == W_IDLE ? (w_commit ? W_RESP : W_IDLE)
            : (s_axi_bready ? W_IDLE : W_RESP);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_rstate <= R_IDLE;
      r_wstate <= W_IDLE;
    end else begin
      r_rstate <= w_rnext;
      r_wstate <= w_wnext;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_up      <= 1'b0;
      r_araddr  <= '0;
      r_cnt     <= '0;
      r_rresp   <= RESP_OKAY;
      r_bresp   <= RESP_OKAY;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      r_up <= 1'b1;
      if (w_ar_hs) begin
        r_araddr <= s_axi_araddr;
        r_cnt    <= 4'(READ_WAIT);
      end else if (r_rstate == R_WAIT) r_cnt <= r_cnt - 4'd1;
      if (w_rd_en) r_rresp <= dec(w_roff, w_raddr[1:0]);
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= s_axi_awaddr;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= s_axi_wdata;
        r_wstrb  <= s_axi_wstrb;
      end
      if (w_commit) r_bresp <= w_wresp;
      if (s_axi_bvalid && s_axi_bready) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end
    end
  end

  axi_lite_mem_array #(.DEPTH(MEM_DEPTH), .IW(IW), .DW(DATA_WIDTH)) u_mem (
    .CLK       (CLK),
    .i_rd_en   (w_rd_en),
    .i_rd_idx  (w_roff[IW+1:2]),
    .o_rd_data (w_rd_data),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (w_woff[IW+1:2]),
    .i_wr_data (w_wr_data),
    .i_wr_strb (w_wr_strb)
  );
endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// tb_axi_lite_mem_slave: scoreboard bench; instance 0 has no read wait states, instance 1 has three.
module tb_axi_lite_mem_slave;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [1:0] OK = 2'b00, SLV = 2'b10, DEC = 2'b11;

  logic clk = 1'b0, rstn = 1'b0;
  logic [1:0] arvalid = '0, arready, rvalid, rready = '1, awvalid = '0, awready;
  logic [1:0] wvalid = '0, wready, bvalid, bready = '1;
  logic [1:0][31:0] araddr = '0, awaddr = '0, wdata = '0, rdata;
  logic [1:0][3:0] wstrb = '0;
  logic [1:0][1:0] rresp, bresp;
  logic [33:0] rq0[$], rq1[$];
  logic [1:0] bq0[$], bq1[$];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  axi_lite_mem_slave #(.MEM_DEPTH(1024), .BASE_ADDR(BASE), .READ_WAIT(0)) d0 (
    .CLK(clk), .RSTN(rstn),
    .s_axi_arvalid(arvalid[0]), .s_axi_arready(arready[0]), .s_axi_araddr(araddr[0]), .s_axi_arprot(3'b000),
    .s_axi_rvalid(rvalid[0]), .s_axi_rready(rready[0]), .s_axi_rdata(rdata[0]), .s_axi_rresp(rresp[0]),
    .s_axi_awvalid(awvalid[0]), .s_axi_awready(awready[0]), .s_axi_awaddr(awaddr[0]), .s_axi_awprot(3'b000),
    .s_axi_wvalid(wvalid[0]), .s_axi_wready(wready[0]), .s_axi_wdata(wdata[0]), .s_axi_wstrb(wstrb[0]),
    .s_axi_bvalid(bvalid[0]), .s_axi_bready(bready[0]), .s_axi_bresp(bresp[0]));

  axi_lite_mem_slave #(.MEM_DEPTH(1024), .BASE_ADDR(BASE), .READ_WAIT(3)) d1 (
    .CLK(clk), .RSTN(rstn),
    .s_axi_arvalid(arvalid[1]), .s_axi_arready(arready[1]), .s_axi_araddr(araddr[1]), .s_axi_arprot(3'b000),
    .s_axi_rvalid(rvalid[1]), .s_axi_rready(rready[1]), .s_axi_rdata(rdata[1]), .s_axi_rresp(rresp[1]),
    .s_axi_awvalid(awvalid[1]), .s_axi_awready(awready[1]), .s_axi_awaddr(awaddr[1]), .s_axi_awprot(3'b000),
    .s_axi_wvalid(wvalid[1]), .s_axi_wready(wready[1]), .s_axi_wdata(wdata[1]), .s_axi_wstrb(wstrb[1]),
    .s_axi_bvalid(bvalid[1]), .s_axi_bready(bready[1]), .s_axi_bresp(bresp[1]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every completed R or B handshake is checked against the oldest expectation.
  always @(negedge clk) begin
    if (rvalid[0] && rready[0]) begin
      chk("r0_expected", 64'(rq0.size() != 0), 1);
      if (rq0.size() != 0) chk("r0_resp_data", {rresp[0], rdata[0]}, rq0.pop_front());
    end
    if (rvalid[1] && rready[1]) begin
      chk("r1_expected", 64'(rq1.size() != 0), 1);
      if (rq1.size() != 0) chk("r1_resp_data", {rresp[1], rdata[1]}, rq1.pop_front());
    end
    if (bvalid[0] && bready[0]) begin
      chk("b0_expected", 64'(bq0.size() != 0), 1);
      if (bq0.size() != 0) chk("b0_resp", bresp[0], bq0.pop_front());
    end
    if (bvalid[1] && bready[1]) begin
      chk("b1_expected", 64'(bq1.size() != 0), 1);
      if (bq1.size() != 0) chk("b1_resp", bresp[1], bq1.pop_front());
    end
  end

  task automatic rd(input int k, input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    int c = 0;
    bit hs = 1'b0;
    if (k == 0) rq0.push_back({r, d}); else rq1.push_back({r, d});
    araddr[k] = a;
    arvalid[k] = 1'b1;
    while (!hs && c < 50) begin
      @(negedge clk);
      hs = arready[k];
      c++;
      @(posedge clk); #1;
    end
    arvalid[k] = 1'b0;
    chk("ar_handshake", 64'(hs), 1);
  endtask

  task automatic wr(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] r, input int da, input int dw);
    int c = 0;
    bit ad = 1'b0, wd = 1'b0;
    while (bvalid[k] && c < 50) begin @(posedge clk); #1; c++; end
    c = 0;
    if (k == 0) bq0.push_back(r); else bq1.push_back(r);
    awaddr[k] = a; wdata[k] = d; wstrb[k] = s;
    while (!(ad && wd) && c < 50) begin
      awvalid[k] = !ad && c >= da;
      wvalid[k] = !wd && c >= dw;
      @(negedge clk);
      if (wd && !ad) chk("wready_drop", 64'(wready[k]), 0);
      if (ad && !wd) chk("awready_drop", 64'(awready[k]), 0);
      chk("bvalid_early", 64'(bvalid[k]), 0);
      ad = ad || (awvalid[k] && awready[k]);
      wd = wd || (wvalid[k] && wready[k]);
      c++;
      @(posedge clk); #1;
    end
    awvalid[k] = 1'b0;
    wvalid[k] = 1'b0;
    chk("aw_w_handshake", 64'(ad && wd), 1);
    chk("bvalid_rise", 64'(bvalid[k]), 1);
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    #1;
    chk("reset_out0", {arready[0], rvalid[0], rdata[0], rresp[0], awready[0], wready[0], bvalid[0], bresp[0]}, 0);
    chk("reset_out1", {arready[1], rvalid[1], rdata[1], rresp[1], awready[1], wready[1], bvalid[1], bresp[1]}, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1 chk("ready_before_edge", {arready, awready, wready}, 0);
    @(posedge clk); #1;
    chk("ready_after_edge", {arready, awready, wready}, 6'h3f);

    // Byte-strobe merge
    wr(0, BASE + 8, 32'hDEADBEEF, 4'hF, OK, 0, 0);
    wr(0, BASE + 8, 32'h0000AA00, 4'b0010, OK, 0, 0);
    rd(0, BASE + 8, 32'hDEADAAEF, OK);

    // Error decode; failed write leaves memory untouched
    wr(0, BASE, 32'h11223344, 4'hF, OK, 0, 0);
    rd(0, BASE + 32'd4096, 32'h0, DEC);
    rd(0, BASE - 32'd4, 32'h0, DEC);
    rd(0, BASE + 1, 32'h0, SLV);
    wr(0, BASE + 2, 32'hFFFFFFFF, 4'hF, SLV, 0, 0);
    wr(0, BASE - 4, 32'hFFFFFFFF, 4'hF, DEC, 0, 0);
    rd(0, BASE, 32'h11223344, OK);

    // AW/W ordering: W first, AW first, together
    wr(0, BASE + 16, 32'h01020304, 4'hF, OK, 3, 0);
    wr(0, BASE + 16, 32'h05060708, 4'hF, OK, 0, 3);
    wr(0, BASE + 16, 32'h090A0B0C, 4'hF, OK, 0, 0);
    rd(0, BASE + 16, 32'h090A0B0C, OK);

    // Same-cycle read and write of one word returns the old value
    wr(0, BASE + 48, 32'hA5A5A5A5, 4'hF, OK, 0, 0);
    settle();
    fork
      rd(0, BASE + 48, 32'hA5A5A5A5, OK);
      wr(0, BASE + 48, 32'h5A5A0000, 4'hF, OK, 0, 0);
    join
    rd(0, BASE + 48, 32'h5A5A0000, OK);

    // Wait states and a stalled R channel
    wr(1, BASE + 32, 32'h0BADF00D, 4'hF, OK, 0, 0);
    settle();
    rready[1] = 1'b0;
    rd(1, BASE + 32, 32'h0BADF00D, OK);
    n = 1;
    while (!rvalid[1] && n < 20) begin @(posedge clk); #1; n++; end
    chk("read_latency_rw3", 64'(n), 4);
    repeat (5) begin
      @(negedge clk);
      chk("r_stall_stable", {rvalid[1], arready[1], rresp[1], rdata[1]}, {1'b1, 1'b0, 2'b00, 32'h0BADF00D});
    end
    @(posedge clk); #1;
    rready[1] = 1'b1;
    rd(1, BASE + 32'd4096, 32'h0, DEC);
    settle();

    // Reset with R and B both pending
    rready[0] = 1'b0;
    bready[0] = 1'b0;
    wr(0, BASE + 64, 32'hCAFEF00D, 4'hF, OK, 0, 0);
    rd(0, BASE + 8, 32'hDEADAAEF, OK);
    chk("pending_valids", {rvalid[0], bvalid[0]}, 2'b11);
    #2 rstn = 1'b0;
    #1 chk("async_reset_out0", {arready[0], rvalid[0], rdata[0], rresp[0], awready[0], wready[0], bvalid[0], bresp[0]}, 0);
    rq0.delete();
    bq0.delete();
    rready[0] = 1'b1;
    bready[0] = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    #1 chk("ready_low_after_release", {arready[0], awready[0], wready[0]}, 0);
    @(posedge clk); #1;
    chk("ready_first_edge", {arready[0], awready[0], wready[0]}, 3'b111);
    rd(0, BASE + 64, 32'hCAFEF00D, OK);
    rd(0, BASE + 8, 32'hDEADAAEF, OK);
    rd(0, BASE, 32'h11223344, OK);
    settle();

    chk("rq0_drained", 64'(rq0.size()), 0);
    chk("rq1_drained", 64'(rq1.size()), 0);
    chk("bq0_drained", 64'(bq0.size()), 0);
    chk("bq1_drained", 64'(bq1.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
